// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the arbiter and shared memory.
// slave  : arbiter side (takes requests, drives the memory port).
// master : environment side (requesters and the memory itself).
interface mem_arbiter_if;
    // Instruction-fetch requester
    logic        if_req;
    logic [15:0] if_addr;
    logic [15:0] if_rdata;
    logic        if_done;
    logic        if_stall;

    // MEM-stage data requester
    logic        d_req;
    logic        d_we;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic [15:0] d_rdata;
    logic        d_done;
    logic        d_stall;

    // Shared memory port
    logic        m_req;
    logic        m_we;
    logic [15:0] m_addr;
    logic [15:0] m_wdata;
    logic [15:0] m_rdata;
    logic        m_ack;

    // Timeout abort indication
    logic        err;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ack,
        output if_rdata, if_done, if_stall, d_rdata, d_done, d_stall,
        output m_req, m_we, m_addr, m_wdata, err
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ack,
        input  if_rdata, if_done, if_stall, d_rdata, d_done, d_stall,
        input  m_req, m_we, m_addr, m_wdata, err
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for a single-port shared memory.
// Data accesses win over fetches, but only for MAX_DATA_RUN consecutive grants while
// a fetch is waiting. Each access runs IDLE -> BUSY -> DONE; an access with no m_ack
// for TIMEOUT busy cycles is aborted and completes with err.
module mem_arbiter #(
    parameter int unsigned MAX_DATA_RUN = 3,
    parameter int unsigned TIMEOUT      = 16
) (
    input  logic          clock,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);

    // Run counter is at least 2 bits wide and saturates at MAX_DATA_RUN.
    localparam int unsigned RunW = (MAX_DATA_RUN < 3) ? 2 : $clog2(MAX_DATA_RUN + 1);
    localparam int unsigned ToW  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    localparam logic [RunW-1:0] RunMax  = RunW'(MAX_DATA_RUN);
    localparam logic [ToW-1:0]  ToLast  = ToW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StBusyIf,
        StBusyD,
        StDone
    } state_e;

    state_e          state_q;
    logic [RunW-1:0] run_q;
    logic [ToW-1:0]  to_q;

    logic            m_req_q;
    logic            m_we_q;
    logic [15:0]     m_addr_q;
    logic [15:0]     m_wdata_q;
    logic [15:0]     if_rdata_q;
    logic [15:0]     d_rdata_q;
    logic            if_done_q;
    logic            d_done_q;
    logic            err_q;

    logic            grant_d;

    // Data wins unless a fetch is waiting and the data run is exhausted.
    always_comb begin
        grant_d = bus.d_req & (~bus.if_req | (run_q < RunMax));
    end

    // Arbitration FSM; every memory-side and requester-side output is registered here.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            run_q      <= '0;
            to_q       <= '0;
            m_req_q    <= 1'b0;
            m_we_q     <= 1'b0;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            if_done_q  <= 1'b0;
            d_done_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            // Completion pulses only live for the single DONE cycle.
            if_done_q <= 1'b0;
            d_done_q  <= 1'b0;
            err_q     <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (grant_d) begin
                        state_q   <= StBusyD;
                        m_req_q   <= 1'b1;
                        m_we_q    <= bus.d_we;
                        m_addr_q  <= bus.d_addr;
                        m_wdata_q <= bus.d_wdata;
                        // Count data grants only while a fetch is being held off.
                        if (bus.if_req) begin
                            if (run_q < RunMax) begin
                                run_q <= run_q + RunW'(1);
                            end
                        end else begin
                            run_q <= '0;
                        end
                    end else if (bus.if_req) begin
                        state_q   <= StBusyIf;
                        m_req_q   <= 1'b1;
                        m_we_q    <= 1'b0;
                        m_addr_q  <= bus.if_addr;
                        m_wdata_q <= '0;
                        run_q     <= '0;
                    end
                end

                StBusyIf, StBusyD: begin
                    if (bus.m_ack) begin
                        state_q <= StDone;
                        m_req_q <= 1'b0;
                        to_q    <= '0;
                        if (state_q == StBusyIf) begin
                            if_done_q  <= 1'b1;
                            if_rdata_q <= bus.m_rdata;
                        end else begin
                            d_done_q <= 1'b1;
                            if (!m_we_q) begin
                                d_rdata_q <= bus.m_rdata;
                            end
                        end
                    end else if (to_q == ToLast) begin
                        // Abort: complete with err, leave read data untouched.
                        state_q <= StDone;
                        m_req_q <= 1'b0;
                        to_q    <= '0;
                        err_q   <= 1'b1;
                        if (state_q == StBusyIf) begin
                            if_done_q <= 1'b1;
                        end else begin
                            d_done_q <= 1'b1;
                        end
                    end else begin
                        to_q <= to_q + ToW'(1);
                    end
                end

                StDone: begin
                    state_q <= StIdle;
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Drive the bus from the registered state.
    assign bus.m_req    = m_req_q;
    assign bus.m_we     = m_we_q;
    assign bus.m_addr   = m_addr_q;
    assign bus.m_wdata  = m_wdata_q;
    assign bus.if_rdata = if_rdata_q;
    assign bus.d_rdata  = d_rdata_q;
    assign bus.if_done  = if_done_q;
    assign bus.d_done   = d_done_q;
    assign bus.err      = err_q;

    // Stalls drop in the done cycle so the pipeline advances exactly once.
    assign bus.if_stall = bus.if_req & ~if_done_q;
    assign bus.d_stall  = bus.d_req & ~d_done_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: zero-wait fetch, simultaneous requests, starvation
// guard, timeout abort, reset mid-access and stall behaviour with wait states.
module tb_mem_arbiter;

    logic clock = 1'b0;
    logic reset = 1'b1;

    int total = 0;
    int bad   = 0;

    // Memory model controls
    logic [15:0] mem_data    = 16'h0000;
    int          wait_states = 0;
    bit          mem_never   = 1'b0;
    int          mem_cnt     = 0;
    logic        mem_ack     = 1'b0;
    logic [15:0] mem_rdata   = 16'h0000;

    mem_arbiter_if bus ();

    assign bus.m_ack   = mem_ack;
    assign bus.m_rdata = mem_rdata;

    mem_arbiter #(
        .MAX_DATA_RUN (3),
        .TIMEOUT      (16)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    // Memory responds after wait_states busy cycles with a single-cycle ack.
    always @(posedge clock) begin
        #1;
        if (bus.m_req === 1'b1 && !mem_ack && !mem_never && mem_cnt == wait_states) begin
            mem_ack   = 1'b1;
            mem_rdata = mem_data;
        end else begin
            mem_ack = 1'b0;
            if (bus.m_req === 1'b1) mem_cnt++;
            else mem_cnt = 0;
        end
    end

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        bus.if_req  = 1'b0;
        bus.if_addr = 16'h0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = 16'h0;
        bus.d_wdata = 16'h0;
        #2 reset = 1'b0;
        #2;
        total++;
        if (bus.m_req !== 1'b0 || bus.m_we !== 1'b0 || bus.m_addr !== 16'h0 ||
            bus.m_wdata !== 16'h0) begin
            bad++;
            $display("FAIL reset_mem: req=%b we=%b addr=%h wdata=%h required all 0",
                     bus.m_req, bus.m_we, bus.m_addr, bus.m_wdata);
        end
        total++;
        if (bus.if_rdata !== 16'h0 || bus.d_rdata !== 16'h0 || bus.if_done !== 1'b0 ||
            bus.d_done !== 1'b0 || bus.err !== 1'b0) begin
            bad++;
            $display("FAIL reset_req: if_rdata=%h d_rdata=%h if_done=%b d_done=%b err=%b required 0",
                     bus.if_rdata, bus.d_rdata, bus.if_done, bus.d_done, bus.err);
        end
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic test_fetch;
        wait_states = 0;
        mem_data    = 16'h4A21;
        bus.if_req  = 1'b1;
        bus.if_addr = 16'h0010;
        #1;
        total++;
        if (bus.if_stall !== 1'b1) begin
            bad++; $display("FAIL fetch_stall: got %b required 1", bus.if_stall);
        end
        step();
        total++;
        if (bus.m_req !== 1'b1 || bus.m_addr !== 16'h0010 || bus.m_we !== 1'b0) begin
            bad++;
            $display("FAIL fetch_busy: req=%b addr=%h we=%b required 1/0010/0",
                     bus.m_req, bus.m_addr, bus.m_we);
        end
        step();
        total++;
        if (bus.if_done !== 1'b1 || bus.if_rdata !== 16'h4A21 || bus.m_req !== 1'b0 ||
            bus.err !== 1'b0) begin
            bad++;
            $display("FAIL fetch_done: done=%b rdata=%h req=%b err=%b required 1/4a21/0/0",
                     bus.if_done, bus.if_rdata, bus.m_req, bus.err);
        end
        bus.if_req = 1'b0;
        step();
        total++;
        if (bus.if_done !== 1'b0 || bus.if_rdata !== 16'h4A21) begin
            bad++;
            $display("FAIL fetch_after: done=%b rdata=%h required 0/4a21",
                     bus.if_done, bus.if_rdata);
        end
    endtask

    task automatic test_simultaneous;
        wait_states = 0;
        mem_data    = 16'h1234;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 16'h0200;
        bus.d_wdata = 16'hBEEF;
        bus.if_req  = 1'b1;
        bus.if_addr = 16'h0040;
        step();
        total++;
        if (bus.m_req !== 1'b1 || bus.m_we !== 1'b1 || bus.m_addr !== 16'h0200 ||
            bus.m_wdata !== 16'hBEEF || bus.d_stall !== 1'b1) begin
            bad++;
            $display("FAIL sim_data_first: req=%b we=%b addr=%h wdata=%h dstall=%b required 1/1/0200/beef/1",
                     bus.m_req, bus.m_we, bus.m_addr, bus.m_wdata, bus.d_stall);
        end
        step();
        total++;
        if (bus.d_done !== 1'b1 || bus.if_done !== 1'b0 || bus.d_stall !== 1'b0 ||
            bus.d_rdata !== 16'h0000) begin
            bad++;
            $display("FAIL sim_data_done: d_done=%b if_done=%b dstall=%b d_rdata=%h required 1/0/0/0000",
                     bus.d_done, bus.if_done, bus.d_stall, bus.d_rdata);
        end
        bus.d_req = 1'b0;
        bus.d_we  = 1'b0;
        step();
        total++;
        if (bus.m_req !== 1'b0) begin
            bad++; $display("FAIL sim_idle: m_req=%b required 0", bus.m_req);
        end
        step();
        total++;
        if (bus.m_req !== 1'b1 || bus.m_addr !== 16'h0040 || bus.m_we !== 1'b0) begin
            bad++;
            $display("FAIL sim_fetch_grant: req=%b addr=%h we=%b required 1/0040/0",
                     bus.m_req, bus.m_addr, bus.m_we);
        end
        step();
        total++;
        if (bus.if_done !== 1'b1 || bus.if_rdata !== 16'h1234) begin
            bad++;
            $display("FAIL sim_fetch_done: done=%b rdata=%h required 1/1234",
                     bus.if_done, bus.if_rdata);
        end
        bus.if_req = 1'b0;
        step();
    endtask

    task automatic test_starvation;
        logic [15:0] exp_seq [8];
        int n;
        exp_seq = '{16'h0300, 16'h0300, 16'h0300, 16'h0050,
                    16'h0300, 16'h0300, 16'h0300, 16'h0050};
        wait_states = 0;
        mem_data    = 16'h5555;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b0;
        bus.d_addr  = 16'h0300;
        bus.if_req  = 1'b1;
        bus.if_addr = 16'h0050;
        for (int g = 0; g < 8; g++) begin
            n = 0;
            while (bus.m_req !== 1'b1 && n < 10) begin
                step();
                n++;
            end
            total++;
            if (n >= 10 || bus.m_addr !== exp_seq[g]) begin
                bad++;
                $display("FAIL starve_grant%0d: addr=%h waited=%0d required %h",
                         g, bus.m_addr, n, exp_seq[g]);
            end
            if (g == 7) begin
                bus.d_req  = 1'b0;
                bus.if_req = 1'b0;
            end
            step();
        end
        step();
        step();
    endtask

    task automatic test_timeout;
        int n;
        mem_never  = 1'b1;
        bus.d_req  = 1'b1;
        bus.d_we   = 1'b0;
        bus.d_addr = 16'h0400;
        n = 0;
        step();
        while (bus.m_req === 1'b1 && n < 40) begin
            n++;
            step();
        end
        total++;
        if (n != 16) begin
            bad++; $display("FAIL timeout_cycles: busy=%0d required 16", n);
        end
        total++;
        if (bus.d_done !== 1'b1 || bus.err !== 1'b1 || bus.d_rdata !== 16'h5555) begin
            bad++;
            $display("FAIL timeout_done: d_done=%b err=%b d_rdata=%h required 1/1/5555",
                     bus.d_done, bus.err, bus.d_rdata);
        end
        bus.d_req = 1'b0;
        step();
        total++;
        if (bus.d_done !== 1'b0 || bus.err !== 1'b0) begin
            bad++;
            $display("FAIL timeout_after: d_done=%b err=%b required 0/0", bus.d_done, bus.err);
        end
        mem_never = 1'b0;
        step();
    endtask

    task automatic test_reset_mid;
        bit seen_done;
        wait_states = 5;
        mem_data    = 16'h6666;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b0;
        bus.d_addr  = 16'h0500;
        step();
        step();
        reset = 1'b0;
        #1;
        total++;
        if (bus.m_req !== 1'b0 || bus.m_addr !== 16'h0 || bus.d_rdata !== 16'h0 ||
            bus.if_rdata !== 16'h0 || bus.d_done !== 1'b0 || bus.err !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_outputs: req=%b addr=%h d_rdata=%h if_rdata=%h d_done=%b err=%b required 0",
                     bus.m_req, bus.m_addr, bus.d_rdata, bus.if_rdata, bus.d_done, bus.err);
        end
        bus.d_req = 1'b0;
        seen_done = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            if (bus.d_done !== 1'b0) seen_done = 1'b1;
        end
        total++;
        if (seen_done) begin
            bad++; $display("FAIL rstmid_no_done: got done pulse required none");
        end
        reset       = 1'b1;
        wait_states = 0;
        mem_data    = 16'h7777;
        bus.d_req   = 1'b1;
        bus.d_addr  = 16'h0600;
        step();
        total++;
        if (bus.m_req !== 1'b1 || bus.m_addr !== 16'h0600) begin
            bad++;
            $display("FAIL rstmid_first_grant: req=%b addr=%h required 1/0600",
                     bus.m_req, bus.m_addr);
        end
        step();
        total++;
        if (bus.d_done !== 1'b1 || bus.d_rdata !== 16'h7777) begin
            bad++;
            $display("FAIL rstmid_served: d_done=%b d_rdata=%h required 1/7777",
                     bus.d_done, bus.d_rdata);
        end
        bus.d_req = 1'b0;
        step();
    endtask

    task automatic test_stall;
        int n;
        wait_states = 3;
        mem_data    = 16'h0A0A;
        bus.if_req  = 1'b1;
        bus.if_addr = 16'h0060;
        #1;
        total++;
        if (bus.if_stall !== 1'b1) begin
            bad++; $display("FAIL stall_request: got %b required 1", bus.if_stall);
        end
        n = 0;
        while (n < 20) begin
            step();
            n++;
            if (bus.if_done === 1'b1) break;
            total++;
            if (bus.if_stall !== 1'b1) begin
                bad++; $display("FAIL stall_busy%0d: got %b required 1", n, bus.if_stall);
            end
        end
        total++;
        if (n != 5 || bus.if_stall !== 1'b0 || bus.if_rdata !== 16'h0A0A) begin
            bad++;
            $display("FAIL stall_done: cycles=%0d stall=%b rdata=%h required 5/0/0a0a",
                     n, bus.if_stall, bus.if_rdata);
        end
        bus.if_req = 1'b0;
        step();
        total++;
        if (bus.if_stall !== 1'b0 || bus.if_done !== 1'b0) begin
            bad++;
            $display("FAIL stall_after: stall=%b done=%b required 0/0", bus.if_stall, bus.if_done);
        end
    endtask

    initial begin
        test_reset();
        step();
        test_fetch();
        test_simultaneous();
        test_starvation();
        test_timeout();
        test_reset_mid();
        test_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
